// File: rtl/ual_issue_pkg.sv
// Shared types and ALU op codes for the UAL issue/writeback slice.
package ual_issue_pkg;
    typedef logic [31:0] v32_t;
    typedef logic [7:0]  v8_t;

    localparam v8_t OP_ADD = 8'h01;
    localparam v8_t OP_SUB = 8'h02;
    localparam v8_t OP_AND = 8'h03;

    localparam int NREGS_DEF = 16;
    localparam int RA_W_DEF  = $clog2(NREGS_DEF);
    typedef logic [RA_W_DEF-1:0] ra_t;
endpackage

// File: rtl/ual_regfile.sv
// NREGS x 32 register file: two combinational read ports, debug read, one write port, r0 reads zero.
module ual_regfile
    import ual_issue_pkg::*;
#(
    parameter int  NREGS = 16,
    localparam int RA_W  = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [RA_W-1:0] ra1,
    output v32_t            rd1,
    input  logic [RA_W-1:0] ra2,
    output v32_t            rd2,
    input  logic [RA_W-1:0] dbg_addr,
    output v32_t            dbg_data,
    input  logic            we,
    input  logic [RA_W-1:0] wa,
    input  v32_t            wd
);
    v32_t regs [NREGS];

    // regs[0] is never written, so it stays at its reset value of zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else if (we && wa != '0) begin
            regs[wa] <= wd;
        end
    end

    assign rd1      = (ra1 == '0)      ? '0 : regs[ra1];
    assign rd2      = (ra2 == '0)      ? '0 : regs[ra2];
    assign dbg_data = (dbg_addr == '0) ? '0 : regs[dbg_addr];
endmodule

// File: rtl/ual_issue.sv
// Issue/writeback stage around a combinational ALU: EX register drives the ALU,
// WB register captures its result with backpressure; forwarding from the EX stage.
module ual_issue
    import ual_issue_pkg::*;
#(
    parameter int  NREGS = 16,
    localparam int RA_W  = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  v8_t             in_op,
    input  logic [RA_W-1:0] in_rd,
    input  logic [RA_W-1:0] in_rs1,
    input  logic [RA_W-1:0] in_rs2,
    input  logic            in_imm_en,
    input  v32_t            in_imm,
    output v32_t            alu_v1,
    output v32_t            alu_v2,
    output v8_t             alu_op,
    input  v32_t            alu_out,
    output logic            wb_valid,
    input  logic            wb_ready,
    output logic [RA_W-1:0] wb_rd,
    output v32_t            wb_data,
    input  logic [RA_W-1:0] dbg_addr,
    output v32_t            dbg_data,
    output v32_t            retired
);
    typedef struct packed {
        v8_t             op;
        logic [RA_W-1:0] rd;
        v32_t            v1;
        v32_t            v2;
    } ex_t;

    ex_t  ex_q;
    logic ex_valid;
    v32_t ret_cnt;
    v32_t rf_rd1, rf_rd2;
    v32_t src1, src2;
    logic adv, acc, ex_go;

    assign adv      = !wb_valid || wb_ready;
    assign in_ready = !ex_valid || adv;
    assign acc      = in_valid && in_ready;
    assign ex_go    = ex_valid && adv;

    ual_regfile #(.NREGS(NREGS)) u_rf (
        .clk      (clk),
        .rst      (rst),
        .ra1      (in_rs1),
        .rd1      (rf_rd1),
        .ra2      (in_rs2),
        .rd2      (rf_rd2),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data),
        .we       (ex_go),
        .wa       (ex_q.rd),
        .wd       (alu_out)
    );

    // The EX instruction writes back on the same edge as the accept, so its
    // result must be taken from the ALU rather than the stale register.
    always_comb begin
        src1 = rf_rd1;
        if (in_rs1 != '0 && ex_valid && ex_q.rd == in_rs1) src1 = alu_out;
        src2 = rf_rd2;
        if (in_rs2 != '0 && ex_valid && ex_q.rd == in_rs2) src2 = alu_out;
        if (in_imm_en) src2 = in_imm;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid <= 1'b0;
            ex_q     <= '0;
        end else if (acc) begin
            ex_valid <= 1'b1;
            ex_q     <= '{op: in_op, rd: in_rd, v1: src1, v2: src2};
        end else if (adv) begin
            ex_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_valid <= 1'b0;
            wb_rd    <= '0;
            wb_data  <= '0;
        end else if (ex_go) begin
            wb_valid <= 1'b1;
            wb_rd    <= ex_q.rd;
            wb_data  <= alu_out;
        end else if (wb_ready) begin
            wb_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                       ret_cnt <= '0;
        else if (wb_valid && wb_ready) ret_cnt <= ret_cnt + 32'd1;
    end

    assign alu_v1  = ex_q.v1;
    assign alu_v2  = ex_q.v2;
    assign alu_op  = ex_q.op;
    assign retired = ret_cnt;
endmodule

// File: tb/tb_ual_issue.sv
// Directed bench for ual_issue with a behavioural UAL on its ALU port.
module tb_ual_issue;
    import ual_issue_pkg::*;

    localparam int NREGS = 16;
    localparam int RA_W  = $clog2(NREGS);

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            in_valid = 1'b0;
    logic            in_ready;
    v8_t             in_op = '0;
    logic [RA_W-1:0] in_rd = '0, in_rs1 = '0, in_rs2 = '0;
    logic            in_imm_en = 1'b0;
    v32_t            in_imm = '0;
    v32_t            alu_v1, alu_v2, alu_out;
    v8_t             alu_op;
    logic            wb_valid;
    logic            wb_ready = 1'b1;
    logic [RA_W-1:0] wb_rd;
    v32_t            wb_data;
    logic [RA_W-1:0] dbg_addr = '0;
    v32_t            dbg_data;
    v32_t            retired;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    // UAL: ADD/SUB/AND, anything else yields 0
    always_comb begin
        case (alu_op)
            OP_ADD:  alu_out = alu_v1 + alu_v2;
            OP_SUB:  alu_out = alu_v1 - alu_v2;
            OP_AND:  alu_out = alu_v1 & alu_v2;
            default: alu_out = '0;
        endcase
    end

    ual_issue #(.NREGS(NREGS)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_imm_en(in_imm_en), .in_imm(in_imm),
        .alu_v1(alu_v1), .alu_v2(alu_v2), .alu_op(alu_op), .alu_out(alu_out),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data), .retired(retired)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input v8_t op, input int rd, input int rs1, input int rs2,
                         input logic imm_en, input v32_t imm);
        in_valid  = 1'b1;
        in_op     = op;
        in_rd     = RA_W'(rd);
        in_rs1    = RA_W'(rs1);
        in_rs2    = RA_W'(rs2);
        in_imm_en = imm_en;
        in_imm    = imm;
    endtask

    task automatic dbg(input string tag, input int a, input v32_t exp);
        dbg_addr = RA_W'(a);
        #1;
        chk(tag, dbg_data, exp);
    endtask

    task automatic chk_wb(input string tag, input int rd, input v32_t data);
        chk({tag, ".v"},  32'(wb_valid), 32'd1);
        chk({tag, ".rd"}, 32'(wb_rd), 32'(rd));
        chk({tag, ".d"},  wb_data, data);
    endtask

    initial begin
        // reset state
        #2;
        chk("rst.wb_valid", 32'(wb_valid), 32'd0);
        chk("rst.alu_v1", alu_v1, 32'd0);
        chk("rst.alu_op", 32'(alu_op), 32'd0);
        chk("rst.wb_data", wb_data, 32'd0);
        chk("rst.retired", retired, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst.in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);

        // back-to-back ADDs with forwarding of r1
        drive(OP_ADD, 1, 0, 0, 1'b1, 32'd5);
        step();
        drive(OP_ADD, 2, 1, 0, 1'b1, 32'd7);
        step();
        in_valid = 1'b0;
        chk_wb("t1.wb0", 1, 32'd5);
        step();
        chk_wb("t1.wb1", 2, 32'd12);
        step();
        chk("t1.wb_idle", 32'(wb_valid), 32'd0);
        chk("t1.v1_hold", alu_v1, 32'd5);
        chk("t1.v2_hold", alu_v2, 32'd7);
        dbg("t1.r2", 2, 32'd12);
        chk("t1.retired", retired, 32'd2);

        // SUB then dependent AND
        drive(OP_SUB, 3, 0, 0, 1'b1, 32'd1);
        step();
        drive(OP_AND, 4, 3, 0, 1'b1, 32'h0000_FFFF);
        step();
        in_valid = 1'b0;
        chk_wb("t2.wb0", 3, 32'hFFFF_FFFF);
        step();
        chk_wb("t2.wb1", 4, 32'h0000_FFFF);
        step();
        dbg("t2.r3", 3, 32'hFFFF_FFFF);
        dbg("t2.r4", 4, 32'h0000_FFFF);

        // backpressure: three ADDs, wb_ready low for 4 cycles
        wb_ready = 1'b0;
        drive(OP_ADD, 5, 0, 0, 1'b1, 32'd1);
        step();
        chk("t3.ready1", 32'(in_ready), 32'd1);
        drive(OP_ADD, 6, 0, 0, 1'b1, 32'd2);
        step();
        drive(OP_ADD, 7, 0, 0, 1'b1, 32'd3);
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("t3.ready0", 32'(in_ready), 32'd0);
            chk_wb("t3.hold", 5, 32'd1);
            step();
        end
        wb_ready = 1'b1;
        #1;
        chk("t3.ready_rel", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        chk_wb("t3.wb1", 6, 32'd2);
        step();
        chk_wb("t3.wb2", 7, 32'd3);
        step();
        chk("t3.drained", 32'(wb_valid), 32'd0);
        chk("t3.retired", retired, 32'd7);
        dbg("t3.r5", 5, 32'd1);

        // write to r0 retires but leaves r0 at zero; following read of r0 is 0
        drive(OP_ADD, 0, 0, 0, 1'b1, 32'd9);
        step();
        drive(OP_ADD, 8, 0, 0, 1'b0, 32'd0);
        step();
        in_valid = 1'b0;
        chk_wb("t4.wb0", 0, 32'd9);
        dbg("t4.r0", 0, 32'd0);
        step();
        chk_wb("t4.wb1", 8, 32'd0);
        step();

        // unknown op code with operands 3 and 4 retires as 0
        drive(8'hFF, 9, 7, 0, 1'b1, 32'd4);
        step();
        in_valid = 1'b0;
        chk("t5.op_v1", alu_v1, 32'd3);
        chk("t5.op_v2", alu_v2, 32'd4);
        step();
        chk_wb("t5.wb", 9, 32'd0);
        step();
        chk("t5.retired", retired, 32'd10);

        // retire counter wrap from a preloaded value
        force dut.ret_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.ret_cnt;
        #1;
        chk("t5.preload", retired, 32'hFFFF_FFFF);
        @(negedge clk);
        drive(OP_ADD, 10, 0, 0, 1'b1, 32'd1);
        step();
        in_valid = 1'b0;
        step();
        step();
        chk("t5.wrap", retired, 32'd0);

        // reset with EX and WB both occupied
        wb_ready = 1'b0;
        drive(OP_ADD, 11, 0, 0, 1'b1, 32'h55);
        step();
        drive(OP_ADD, 12, 0, 0, 1'b1, 32'h66);
        step();
        in_valid = 1'b0;
        chk_wb("t6.pre", 11, 32'h55);
        rst = 1'b1;
        #1;
        chk("t6.wb_valid", 32'(wb_valid), 32'd0);
        chk("t6.retired", retired, 32'd0);
        chk("t6.alu_v2", alu_v2, 32'd0);
        dbg("t6.r2", 2, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        wb_ready = 1'b1;
        step();
        step();
        chk("t6.idle", 32'(wb_valid), 32'd0);
        dbg("t6.r11", 11, 32'd0);
        dbg("t6.r12", 12, 32'd0);
        chk("t6.in_ready", 32'(in_ready), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
